// File: rtl/alu_issue_ctrl.sv
// Issue controller between decode and a combinational 32-bit ALU: decodes R-type funct,
// drives registered ALU controls, captures the result and returns a tagged response.
module alu_issue_ctrl #(
    parameter int unsigned TRAP_OVF = 1,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [5:0]       req_funct,
    input  logic [4:0]       req_shamt,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_tag,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [1:0]       alu_mode,
    output logic [3:0]       alu_opcode,
    output logic [4:0]       alu_shamt,
    input  logic [31:0]      alu_result,
    input  logic [1:0]       alu_overflow,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_tag,
    output logic             rsp_ovf,
    output logic             rsp_err,
    output logic             sticky_ovf,
    input  logic             clr_sticky,
    output logic [CNT_W-1:0] op_count
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam bit LP_TRAP = (TRAP_OVF != 0);

    state_t           r_state;
    logic             r_req_ready;
    logic [31:0]      r_alu_a;
    logic [31:0]      r_alu_b;
    logic [1:0]       r_alu_mode;
    logic [3:0]       r_alu_opcode;
    logic [4:0]       r_alu_shamt;
    logic             r_sarith;
    logic             r_illegal;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic [3:0]       r_rsp_tag;
    logic             r_rsp_ovf;
    logic             r_rsp_err;
    logic             r_sticky;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_opcode;
    logic             w_signed;
    logic             w_shift;
    logic             w_legal;
    logic             w_sarith;
    logic             w_unused_ovf1;

    assign w_unused_ovf1 = alu_overflow[1];

    always_comb begin
        w_opcode = '0;
        w_signed = 1'b0;
        w_shift  = 1'b0;
        w_legal  = 1'b1;
        w_sarith = 1'b0;
        case (req_funct)
            6'h20: begin w_opcode = 4'b0000; w_signed = 1'b1; w_sarith = 1'b1; end
            6'h21: begin w_opcode = 4'b0000; end
            6'h22: begin w_opcode = 4'b0001; w_signed = 1'b1; w_sarith = 1'b1; end
            6'h23: begin w_opcode = 4'b0001; end
            6'h24: begin w_opcode = 4'b0010; end
            6'h25: begin w_opcode = 4'b0011; end
            6'h00: begin w_opcode = 4'b0100; w_shift = 1'b1; end
            6'h02: begin w_opcode = 4'b0101; w_shift = 1'b1; end
            6'h03: begin w_opcode = 4'b0110; w_shift = 1'b1; end
            6'h2A: begin w_opcode = 4'b1000; w_signed = 1'b1; end
            6'h2B: begin w_opcode = 4'b1000; end
            6'h2C: begin w_opcode = 4'b0111; w_signed = 1'b1; end
            6'h2D: begin w_opcode = 4'b0111; end
            default: w_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_req_ready  <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_mode   <= '0;
            r_alu_opcode <= '0;
            r_alu_shamt  <= '0;
            r_sarith     <= 1'b0;
            r_illegal    <= 1'b0;
            r_rsp_valid  <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_tag    <= '0;
            r_rsp_ovf    <= 1'b0;
            r_rsp_err    <= 1'b0;
            r_sticky     <= 1'b0;
            r_count      <= '0;
        end else begin
            // a signed overflow captured this edge beats a simultaneous clear
            if (r_state == EXEC && r_sarith && alu_overflow[0])
                r_sticky <= 1'b1;
            else if (clr_sticky)
                r_sticky <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_alu_a      <= !w_legal ? '0 : (w_shift ? req_b : req_a);
                        r_alu_b      <= (w_legal && !w_shift) ? req_b : '0;
                        r_alu_shamt  <= (w_legal && w_shift) ? req_shamt : '0;
                        r_alu_opcode <= w_opcode;
                        r_alu_mode   <= {1'b0, w_signed};
                        r_sarith     <= w_sarith;
                        r_illegal    <= !w_legal;
                        r_rsp_tag    <= req_tag;
                        r_req_ready  <= 1'b0;
                        r_state      <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_data  <= r_illegal ? '0 : alu_result;
                    r_rsp_ovf   <= !r_illegal && alu_overflow[0];
                    r_rsp_err   <= r_illegal || (LP_TRAP && r_sarith && alu_overflow[0]);
                    r_rsp_valid <= 1'b1;
                    r_state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        if (r_count != '1)
                            r_count <= r_count + CNT_W'(1);
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_req_ready <= 1'b1;
                    r_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready  = r_req_ready;
    assign alu_a      = r_alu_a;
    assign alu_b      = r_alu_b;
    assign alu_mode   = r_alu_mode;
    assign alu_opcode = r_alu_opcode;
    assign alu_shamt  = r_alu_shamt;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_data   = r_rsp_data;
    assign rsp_tag    = r_rsp_tag;
    assign rsp_ovf    = r_rsp_ovf;
    assign rsp_err    = r_rsp_err;
    assign sticky_ovf = r_sticky;
    assign op_count   = r_count;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Scoreboard bench for alu_issue_ctrl: a behavioural ALU closes the loop, a funct-level
// reference model predicts each response, and a negedge monitor compares.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [5:0]  req_funct;
    logic [4:0]  req_shamt;
    logic [31:0] req_a, req_b;
    logic [3:0]  req_tag;
    logic [31:0] alu_a, alu_b, alu_result;
    logic [1:0]  alu_mode, alu_overflow;
    logic [3:0]  alu_opcode;
    logic [4:0]  alu_shamt;
    logic        rsp_valid, rsp_ready, rsp_ovf, rsp_err, sticky_ovf, clr_sticky;
    logic [31:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic [15:0] op_count;

    logic        s_req_ready, s_rsp_valid, s_rsp_ovf, s_rsp_err, s_sticky;
    logic [31:0] s_rsp_data;
    logic [3:0]  s_rsp_tag;
    logic [1:0]  s_op_count;
    logic [31:0] unused_s_alu_a, unused_s_alu_b;
    logic [1:0]  unused_s_alu_mode;
    logic [3:0]  unused_s_alu_opcode;
    logic [4:0]  unused_s_alu_shamt;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.TRAP_OVF(1), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_funct(req_funct), .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .alu_a(alu_a), .alu_b(alu_b), .alu_mode(alu_mode),
        .alu_opcode(alu_opcode), .alu_shamt(alu_shamt), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_tag(rsp_tag), .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .sticky_ovf(sticky_ovf), .clr_sticky(clr_sticky), .op_count(op_count));

    // Second instance: no overflow trap and a 2-bit counter to reach saturation quickly
    alu_issue_ctrl #(.TRAP_OVF(0), .CNT_W(2)) u_sat (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_funct(req_funct), .req_shamt(req_shamt), .req_a(req_a), .req_b(req_b),
        .req_tag(req_tag), .alu_a(unused_s_alu_a), .alu_b(unused_s_alu_b),
        .alu_mode(unused_s_alu_mode), .alu_opcode(unused_s_alu_opcode),
        .alu_shamt(unused_s_alu_shamt), .alu_result(alu_result),
        .alu_overflow(alu_overflow), .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(s_rsp_data), .rsp_tag(s_rsp_tag), .rsp_ovf(s_rsp_ovf), .rsp_err(s_rsp_err),
        .sticky_ovf(s_sticky), .clr_sticky(clr_sticky), .op_count(s_op_count));

    // Behavioural ALU; overflow bit 1 is held high so only bit 0 may matter
    logic [32:0] t_alu;
    logic        alu_ovf0;
    always_comb begin
        t_alu      = '0;
        alu_result = '0;
        alu_ovf0   = 1'b0;
        case (alu_opcode)
            4'h0: begin
                t_alu = {1'b0, alu_a} + {1'b0, alu_b};
                alu_result = t_alu[31:0];
                alu_ovf0 = alu_mode[0] ? (alu_a[31] == alu_b[31] && t_alu[31] != alu_a[31]) : t_alu[32];
            end
            4'h1: begin
                t_alu = {1'b0, alu_a} - {1'b0, alu_b};
                alu_result = t_alu[31:0];
                alu_ovf0 = alu_mode[0] ? (alu_a[31] != alu_b[31] && t_alu[31] != alu_a[31]) : t_alu[32];
            end
            4'h2: alu_result = alu_a & alu_b;
            4'h3: alu_result = alu_a | alu_b;
            4'h4: alu_result = alu_a << alu_shamt;
            4'h5: alu_result = alu_a >> alu_shamt;
            4'h6: alu_result = $signed(alu_a) >>> alu_shamt;
            4'h7: alu_result = {31'b0, alu_mode[0] ? ($signed(alu_a) > $signed(alu_b)) : (alu_a > alu_b)};
            4'h8: alu_result = {31'b0, alu_mode[0] ? ($signed(alu_a) < $signed(alu_b)) : (alu_a < alu_b)};
            default: alu_result = '0;
        endcase
    end
    assign alu_overflow = {1'b1, alu_ovf0};

    typedef struct {
        logic [31:0] data;
        logic [3:0]  tag;
        logic        ovf;
        logic        err;
        logic        err_notrap;
        logic        sovf;
        logic [31:0] xa;
        logic [31:0] xb;
        logic [4:0]  xsh;
        int unsigned acc;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned exp_cnt = 0;
    logic        exp_sticky = 1'b0;
    logic        cap_pend = 1'b0;
    logic        cap_sovf = 1'b0;
    int unsigned n_chk = 0;
    int unsigned n_fail = 0;
    bit          rand_bp = 1'b0;
    bit          rand_clr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, expv, $time);
        end
    endtask

    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] sh);
        exp_t   e;
        longint r;
        longint unsigned u;
        logic   illegal;
        illegal = 1'b0;
        e.data = '0; e.tag = '0; e.ovf = 1'b0; e.sovf = 1'b0; e.acc = 0;
        e.xa = a; e.xb = b; e.xsh = '0;
        case (f)
            6'h20: begin r = longint'($signed(a)) + longint'($signed(b)); e.data = r[31:0];
                         e.sovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); e.ovf = e.sovf; end
            6'h22: begin r = longint'($signed(a)) - longint'($signed(b)); e.data = r[31:0];
                         e.sovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); e.ovf = e.sovf; end
            6'h21: begin u = longint'(a) + longint'(b); e.data = u[31:0]; e.ovf = (u > 64'hFFFF_FFFF); end
            6'h23: begin e.data = a - b; e.ovf = (a < b); end
            6'h24: e.data = a & b;
            6'h25: e.data = a | b;
            6'h00: begin e.data = b << sh; e.xa = b; e.xb = '0; e.xsh = sh; end
            6'h02: begin e.data = b >> sh; e.xa = b; e.xb = '0; e.xsh = sh; end
            6'h03: begin e.data = $signed(b) >>> sh; e.xa = b; e.xb = '0; e.xsh = sh; end
            6'h2A: e.data = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            6'h2B: e.data = (a < b) ? 32'd1 : 32'd0;
            6'h2C: e.data = ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
            6'h2D: e.data = (a > b) ? 32'd1 : 32'd0;
            default: begin illegal = 1'b1; e.xa = '0; e.xb = '0; end
        endcase
        e.err        = illegal || e.sovf;
        e.err_notrap = illegal;
        return e;
    endfunction

    // Model state advances on the clock edge using pre-edge input values
    always @(posedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (cap_pend && cap_sovf) exp_sticky = 1'b1;
            else if (clr_sticky)      exp_sticky = 1'b0;
            cap_pend = 1'b0;
            if (q.size() > 0 && cyc >= q[0].acc + 2 && rsp_ready) begin
                void'(q.pop_front());
                if (exp_cnt < 65535) exp_cnt++;
            end else if (q.size() == 0 && req_valid) begin
                e = model(req_funct, req_a, req_b, req_shamt);
                e.tag = req_tag;
                e.acc = cyc;
                q.push_back(e);
                cap_pend = 1'b1;
                cap_sovf = e.sovf;
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        if (rst_n) begin
            logic vld;
            vld = (q.size() > 0) && (cyc >= q[0].acc + 2);
            chk("req_ready", req_ready, q.size() == 0);
            chk("sticky_ovf", sticky_ovf, exp_sticky);
            chk("op_count", op_count, exp_cnt);
            chk("sat_op_count", s_op_count, (exp_cnt > 3) ? 3 : exp_cnt);
            chk("rsp_valid", rsp_valid, vld);
            if (vld) begin
                chk("rsp_data", rsp_data, q[0].data);
                chk("rsp_tag", rsp_tag, q[0].tag);
                chk("rsp_ovf", rsp_ovf, q[0].ovf);
                chk("rsp_err", rsp_err, q[0].err);
                chk("notrap_rsp_err", s_rsp_err, q[0].err_notrap);
            end
            if (q.size() > 0 && cyc == q[0].acc + 1) begin
                chk("exec_alu_a", alu_a, q[0].xa);
                chk("exec_alu_b", alu_b, q[0].xb);
                chk("exec_alu_shamt", alu_shamt, q[0].xsh);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        if (rand_bp)  rsp_ready  = ($urandom_range(2) != 0);
        if (rand_clr) clr_sticky = ($urandom_range(4) == 0);
    endtask

    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [3:0] tg, input bit clr_exec);
        int unsigned n;
        tick();
        req_valid = 1'b1; req_funct = f; req_a = a; req_b = b; req_shamt = sh; req_tag = tg;
        n = 0;
        while (!req_ready && n < 100) begin tick(); n++; end
        if (n >= 100) chk("accept_timeout", 1, 0);
        tick();
        req_valid = 1'b0;
        req_funct = 6'($urandom); req_a = $urandom; req_b = $urandom;
        req_shamt = 5'($urandom); req_tag = 4'($urandom);
        if (clr_exec) begin clr_sticky = 1'b1; tick(); clr_sticky = 1'b0; end
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        while (q.size() != 0 && n < 200) begin tick(); n++; end
        if (n >= 200) chk("response_timeout", 1, 0);
    endtask

    task automatic check_reset_outputs(input string ph);
        chk({ph, "_req_ready"}, req_ready, 1);
        chk({ph, "_rsp_valid"}, rsp_valid, 0);
        chk({ph, "_alu_a"}, alu_a, 0);
        chk({ph, "_alu_b"}, alu_b, 0);
        chk({ph, "_alu_ctl"}, {alu_mode, alu_opcode, alu_shamt}, 0);
        chk({ph, "_rsp_data"}, rsp_data, 0);
        chk({ph, "_rsp_flags"}, {rsp_tag, rsp_ovf, rsp_err, sticky_ovf}, 0);
        chk({ph, "_op_count"}, op_count, 0);
    endtask

    task automatic flush_model();
        q.delete();
        cap_pend = 1'b0; exp_sticky = 1'b0; exp_cnt = 0;
    endtask

    logic [5:0] legal_f [13] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h00,
                                 6'h02, 6'h03, 6'h2A, 6'h2B, 6'h2C, 6'h2D};
    logic [31:0] edge_v [5] = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};

    function automatic logic [31:0] pick_val();
        if ($urandom_range(2) == 0) return edge_v[$urandom_range(4)];
        return $urandom;
    endfunction

    initial begin
        int unsigned n;
        logic [5:0] f;
        rst_n = 1'b1; req_valid = 1'b0; req_funct = '0; req_shamt = '0; req_a = '0;
        req_b = '0; req_tag = '0; rsp_ready = 1'b1; clr_sticky = 1'b0;
        #1 rst_n = 1'b0;
        #2 check_reset_outputs("reset");
        tick(); tick();
        rst_n = 1'b1;

        issue(6'h20, 32'h7FFF_FFFF, 32'h1, 5'd0, 4'd5, 1'b0);
        wait_done();
        tick();
        chk("sticky_after_add_ovf", sticky_ovf, 1);

        issue(6'h2A, -32'sd800, 32'd6, 5'd0, 4'd1, 1'b0);
        wait_done();
        issue(6'h2B, -32'sd800, 32'd6, 5'd0, 4'd2, 1'b0);
        wait_done();
        issue(6'h03, 32'h1234_5678, 32'hF000_0000, 5'd4, 4'd3, 1'b0);
        wait_done();

        // Backpressure with a competing request that must be ignored
        rsp_ready = 1'b0;
        issue(6'h25, 32'h0F0F_0000, 32'h0000_00F0, 5'd0, 4'd9, 1'b0);
        n = 0;
        while (!rsp_valid && n < 10) begin tick(); n++; end
        req_valid = 1'b1; req_funct = 6'h22; req_a = 32'h5; req_b = 32'h3; req_tag = 4'hA;
        tick(); tick(); tick();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        wait_done();
        tick();

        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        issue(6'h21, 32'hFFFF_FFFF, 32'h1, 5'd0, 4'd4, 1'b0);
        wait_done();
        issue(6'h3F, 32'h1234, 32'h5678, 5'd3, 4'd6, 1'b0);
        wait_done();
        issue(6'h22, 32'h8000_0000, 32'h1, 5'd0, 4'd7, 1'b1);
        wait_done();
        tick();
        chk("sticky_set_beats_clear", sticky_ovf, 1);
        clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
        tick();

        // Asynchronous reset while EXEC is in progress
        issue(6'h20, 32'h1, 32'h2, 5'd0, 4'd8, 1'b0);
        #1 rst_n = 1'b0;
        flush_model();
        #1 check_reset_outputs("midop_reset");
        tick(); tick();
        rst_n = 1'b1;
        issue(6'h24, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 4'd2, 1'b0);
        wait_done();
        tick();
        chk("op_count_after_reset", op_count, 1);

        rand_bp = 1'b1; rand_clr = 1'b1;
        for (int i = 0; i < 60; i++) begin
            f = ($urandom_range(7) == 0) ? 6'($urandom) : legal_f[$urandom_range(12)];
            issue(f, pick_val(), pick_val(), 5'($urandom), 4'($urandom), 1'b0);
        end
        wait_done();
        rand_bp = 1'b0; rand_clr = 1'b0;
        rsp_ready = 1'b1; clr_sticky = 1'b0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
